// File: rtl/bvlshr_slt_witness_checker_if.sv
// Handshake bus of the witness checker: one (s, t, x) triple in, one
// verdict (sat, ic, fail) out, each with its own valid/ready pair.
interface bvlshr_slt_witness_checker_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic [W-1:0] t;
  logic [W-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic         out_sat;
  logic         out_ic;
  logic         out_fail;

  // Producer of triples / consumer of verdicts.
  modport master (
    output in_valid, s, t, x, out_ready,
    input  in_ready, out_valid, out_sat, out_ic, out_fail
  );

  // The checker itself.
  modport slave (
    input  in_valid, s, t, x, out_ready,
    output in_ready, out_valid, out_sat, out_ic, out_fail
  );
endinterface

// File: rtl/bvlshr_slt_witness_checker.sv
// Witness checker for the invertibility condition of (x >> s) <s t.
// x is shifted right one bit per cycle (zero fill), then compared signed
// against t. The IC is evaluated from s and t at accept; a triple whose IC
// holds but whose x does not satisfy the constraint is flagged as a failure.
// check_count / fail_count are saturating counters of output handshakes.
module bvlshr_slt_witness_checker #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  bvlshr_slt_witness_checker_if.slave bus,
  output logic [CW-1:0]               check_count,
  output logic [CW-1:0]               fail_count
);

  // Shift counter must be able to hold W itself (s >= W clamps to W).
  localparam int CNTW = $clog2(W + 1);
  localparam logic [W-1:0] T_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    shreg;
  logic [W-1:0]    t_q;
  logic [CNTW-1:0] cnt;
  logic            ic_q;
  logic            sat_q;
  logic            ic_out_q;
  logic            fail_q;

  logic            accept;
  logic            handshake;
  logic            s_big;
  logic            ic_now;
  logic            sat_now;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign handshake = (state == DONE) && bus.out_ready;

  // Shift amounts of W or more all produce zero, so clamp to W shifts.
  assign s_big = {1'b0, bus.s} >= (W + 1)'(W);

  // IC: t strictly positive, or no shift at all and t is not the minimum.
  assign ic_now = (!bus.t[W-1] && (bus.t != '0)) ||
                  ((bus.s == '0) && (bus.t != T_MIN));

  assign sat_now = $signed(shreg) < $signed(t_q);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sat   = sat_q;
  assign bus.out_ic    = ic_out_q;
  assign bus.out_fail  = fail_q;

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> shift until cnt reaches 0 -> hold result.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture the triple, shift one bit per cycle, register verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      t_q      <= '0;
      cnt      <= '0;
      ic_q     <= 1'b0;
      sat_q    <= 1'b0;
      ic_out_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= bus.x;
            t_q   <= bus.t;
            cnt   <= s_big ? CNTW'(W) : CNTW'(bus.s);
            ic_q  <= ic_now;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            shreg <= shreg >> 1;
            cnt   <= cnt - CNTW'(1);
          end else begin
            sat_q    <= sat_now;
            ic_out_q <= ic_q;
            fail_q   <= ic_q & ~sat_now;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating counters; clr wins over a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_count <= '0;
      fail_count  <= '0;
    end else if (clr) begin
      check_count <= '0;
      fail_count  <= '0;
    end else if (handshake) begin
      if (check_count != '1) check_count <= check_count + CW'(1);
      if (fail_q && (fail_count != '1)) fail_count <= fail_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_bvlshr_slt_witness_checker.sv
// Bench for bvlshr_slt_witness_checker (W=4, CW=4). A behavioural model of
// the constraint and the IC predicts every verdict; a compare process checks
// outputs and counters on every falling edge; directed triples carry
// hand-computed expectations.
module tb_bvlshr_slt_witness_checker;

  localparam int W  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [CW-1:0] check_count;
  logic [CW-1:0] fail_count;

  bvlshr_slt_witness_checker_if #(.W(W)) bus ();

  bvlshr_slt_witness_checker #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .bus         (bus),
    .check_count (check_count),
    .fail_count  (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected verdict of the triple currently in flight.
  logic exp_armed = 1'b0;
  logic exp_sat   = 1'b0;
  logic exp_ic    = 1'b0;
  logic exp_fail  = 1'b0;

  // Model counters.
  int m_chk = 0;
  int m_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Constraint and IC straight from their definitions, in plain integers.
  function automatic logic [2:0] model(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x);
    int shifted;
    int ts;
    int ss;
    logic sat;
    logic ic;
    shifted = (s >= W) ? 0 : (int'(x) >> s);
    ss = (shifted >= 8) ? shifted - 16 : shifted;
    ts = (t >= 8) ? int'(t) - 16 : int'(t);
    sat = (ss < ts);
    ic  = (ts > 0) || (s == 0 && ts != -8);
    return {sat, ic, ic && !sat};
  endfunction

  // Compare process: outputs and counters every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_sat", bus.out_sat, 1'b0);
      check("rst_check_count", check_count, 0);
      check("rst_fail_count", fail_count, 0);
      m_chk = 0;
      m_fail = 0;
    end else begin
      check("check_count", check_count, m_chk);
      check("fail_count", fail_count, m_fail);
      if (bus.out_valid) begin
        check("valid_expected", exp_armed, 1'b1);
        check("out_sat", bus.out_sat, exp_sat);
        check("out_ic", bus.out_ic, exp_ic);
        check("out_fail", bus.out_fail, exp_fail);
        check("in_ready_in_done", bus.in_ready, 1'b0);
      end
      if (clr) begin
        m_chk = 0;
        m_fail = 0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (m_chk < CMAX) m_chk++;
        if (exp_fail && m_fail < CMAX) m_fail++;
      end
    end
  end

  // Drive one triple; optionally pin the verdict against literal values.
  task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x,
                      input int ready_delay, input logic clr_hs,
                      input logic use_lit, input logic [2:0] lit, input int lit_lat);
    int wait_n;
    int lat;
    logic [2:0] m;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("in_ready_wait", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.s = s;
    bus.t = t;
    bus.x = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.s = 4'($urandom);
    bus.t = 4'($urandom);
    bus.x = 4'($urandom);
    m = model(s, t, x);
    exp_sat = m[2];
    exp_ic = m[1];
    exp_fail = m[0];
    exp_armed = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ((s >= W) ? W : int'(s)) + 1);
    if (use_lit) begin
      check("lit_latency", lat, lit_lat);
      check("lit_sat", bus.out_sat, lit[2]);
      check("lit_ic", bus.out_ic, lit[1]);
      check("lit_fail", bus.out_fail, lit[0]);
    end
    repeat (ready_delay) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    clr = clr_hs;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    clr = 1'b0;
    exp_armed = 1'b0;
    check("valid_drop", bus.out_valid, 1'b0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.s = '0;
    bus.t = '0;
    bus.x = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_fail", bus.out_fail, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // s=0, t=3, x=2: 2 < 3.
    send(4'd0, 4'b0011, 4'b0010, 0, 1'b0, 1'b1, 3'b110, 1);
    // s=2, t=0, x=F: 0011 < 0 false; IC false.
    send(4'd2, 4'b0000, 4'b1111, 0, 1'b0, 1'b1, 3'b000, 3);
    // Fresh counters, then a failing triple.
    pulse_clr();
    send(4'd1, 4'b0001, 4'b0010, 0, 1'b0, 1'b1, 3'b011, 2);
    check("t3_check_count", check_count, 1);
    check("t3_fail_count", fail_count, 1);
    // Oversized shift: result 0, 0 < 1.
    send(4'd15, 4'b0001, 4'b1111, 0, 1'b0, 1'b1, 3'b110, 5);
    // t = MIN: nothing is below it, no solution exists.
    send(4'd15, 4'b1000, 4'b1111, 0, 1'b0, 1'b1, 3'b000, 5);
    // Consumer stalls 10 cycles in DONE.
    send(4'd2, 4'b0011, 4'b0001, 10, 1'b0, 1'b1, 3'b110, 3);
    check("t5_check_count", check_count, 4);

    // Reset mid-SHIFT drops the in-flight triple.
    bus.in_valid = 1'b1;
    bus.s = 4'd15;
    bus.t = 4'b0001;
    bus.x = 4'b1111;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_out_sat", bus.out_sat, 1'b0);
    check("midrst_out_ic", bus.out_ic, 1'b0);
    check("midrst_check_count", check_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_out_valid", bus.out_valid, 1'b0);

    // Exhaustive sweep against the model.
    for (int s = 0; s < 16; s++)
      for (int t = 0; t < 16; t++)
        for (int x = 0; x < 16; x++)
          send(4'(s), 4'(t), 4'(x), 0, 1'b0, 1'b0, 3'b000, 0);

    // Saturation of fail_count.
    pulse_clr();
    for (int i = 0; i < 17; i++)
      send(4'd1, 4'b0001, 4'b0010, 0, 1'b0, 1'b0, 3'b000, 0);
    check("sat_fail_count", fail_count, 4'hF);
    check("sat_check_count", check_count, 4'hF);

    // clr during a handshake wins.
    send(4'd1, 4'b0001, 4'b0010, 0, 1'b1, 1'b1, 3'b011, 2);
    check("clr_hs_check_count", check_count, 0);
    check("clr_hs_fail_count", fail_count, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
